// File: rtl/ppu_line_fetcher.sv
// Scanline fetcher: prefetches one source row from VRAM into a double-buffered
// line buffer and emits 2x-scaled pixels with sync delayed to match.
module ppu_line_fetcher #(
    parameter int unsigned       SRC_W     = 320,
    parameter int unsigned       SRC_H     = 240,
    parameter int unsigned       PIX_W     = 8,
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pixel_o,
    output logic              pixel_valid,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              underrun
);

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned COL_W     = $clog2(SRC_W);
    localparam int unsigned ROW_W     = $clog2(SRC_H);
    localparam int unsigned H_LAST    = 799;
    localparam int unsigned V_PREROW  = 522;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               disp_bank_q, disp_bank_d;
    logic [ROW_W-1:0]   fetch_row_q, fetch_row_d;
    logic [COL_W-1:0]   fetch_col_q, fetch_col_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               underrun_q, underrun_d;
    logic [PIX_W-1:0]   pixel_q;
    logic               pixel_valid_q;
    logic               hsync_q;
    logic               vsync_q;

    logic [PIX_W-1:0]   bank0_q [SRC_W];
    logic [PIX_W-1:0]   bank1_q [SRC_W];

    logic [CNT_W-1:0]   v_half_c;
    logic               trig_c;
    logic [ROW_W-1:0]   trig_row_c;
    logic               swap_c;
    logic               wr_en_c;
    logic [COL_W-1:0]   rd_idx_c;
    logic [PIX_W-1:0]   rd_pix_c;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        return BASE_ADDR + ADDR_W'(row) * ADDR_W'(SRC_W) + ADDR_W'(col);
    endfunction

    // Row-fetch trigger at the start of each even line, plus row 0 ahead of the frame
    assign v_half_c = {1'b0, v_count[CNT_W-1:1]};
    always_comb begin
        trig_c     = 1'b0;
        trig_row_c = '0;
        if (h_count == '0) begin
            if (!v_count[0] && ((v_half_c + CNT_W'(1)) < CNT_W'(SRC_H))) begin
                trig_c     = 1'b1;
                trig_row_c = ROW_W'(v_half_c + CNT_W'(1));
            end else if (v_count == CNT_W'(V_PREROW)) begin
                trig_c     = 1'b1;
                trig_row_c = '0;
            end
        end
    end

    assign swap_c  = (h_count == CNT_W'(H_LAST)) && v_count[0];
    assign wr_en_c = (state_q == ST_FETCH) && mem_req_q && mem_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            disp_bank_q <= 1'b0;
            fetch_row_q <= '0;
            fetch_col_q <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            disp_bank_q <= disp_bank_d;
            fetch_row_q <= fetch_row_d;
            fetch_col_q <= fetch_col_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        disp_bank_d = disp_bank_q;
        fetch_row_d = fetch_row_q;
        fetch_col_d = fetch_col_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        underrun_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                underrun_d = swap_c;
                if (trig_c) begin
                    state_d     = ST_FETCH;
                    fetch_row_d = trig_row_c;
                    fetch_col_d = '0;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = addr_of(trig_row_c, '0);
                end
            end
            ST_FETCH: begin
                // A late fetch keeps running; the swap point only flags it
                underrun_d = swap_c;
                if (wr_en_c) begin
                    if (fetch_col_q == COL_W'(SRC_W - 1)) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_READY;
                    end else begin
                        fetch_col_d = fetch_col_q + COL_W'(1);
                        mem_addr_d  = addr_of(fetch_row_q, fetch_col_q + COL_W'(1));
                    end
                end
            end
            ST_READY: begin
                if (swap_c) begin
                    disp_bank_d = ~disp_bank_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch writes the bank not on display
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            if (disp_bank_q) begin
                bank0_q[fetch_col_q] <= mem_rdata;
            end else begin
                bank1_q[fetch_col_q] <= mem_rdata;
            end
        end
    end

    assign rd_idx_c = COL_W'(h_count >> 1);
    always_comb begin
        rd_pix_c = '0;
        if (rd_idx_c < COL_W'(SRC_W)) begin
            rd_pix_c = disp_bank_q ? bank1_q[rd_idx_c] : bank0_q[rd_idx_c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
        end else begin
            pixel_q       <= video_on ? rd_pix_c : '0;
            pixel_valid_q <= video_on;
            hsync_q       <= hsync_in;
            vsync_q       <= vsync_in;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign underrun    = underrun_q;
    assign pixel_o     = pixel_q;
    assign pixel_valid = pixel_valid_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;

endmodule
